// File: rtl/mem_stage.sv
// MIPS memory-access stage: branch resolution, multi-cycle data-memory access with stall
// handshake, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  WB_IN,
    input  logic [2:0]  MEM_IN,
    input  logic [31:0] BranchPC_IN,
    input  logic        Zero_IN,
    input  logic [31:0] AluResult_IN,
    input  logic [31:0] RD2_IN,
    input  logic [4:0]  WR_IN,
    output logic        PCSrc,
    output logic [31:0] BranchPC,
    output logic        Stall,
    output logic [1:0]  WB_OUT,
    output logic [31:0] ReadData_OUT,
    output logic [31:0] AluResult_OUT,
    output logic [4:0]  WR_OUT,
    output logic        Fault_OUT
);

    localparam int unsigned CntW  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam bit          Multi = (LATENCY > 1);
    localparam logic [CntW-1:0] CntLoad = CntW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      wb_q;
    logic [31:0]     rdata_q;
    logic [31:0]     alu_q;
    logic [4:0]      wr_q;
    logic            fault_q;

    logic [31:0] mem_q [DEPTH];

    logic                 mem_read;
    logic                 mem_write;
    logic                 access;
    logic                 misaligned;
    logic                 aligned_acc;
    logic [ADDR_BITS-1:0] idx;
    logic                 stall_c;
    logic                 complete_c;

    assign mem_read    = MEM_IN[1];
    assign mem_write   = MEM_IN[0];
    assign access      = mem_read | mem_write;
    assign misaligned  = access & (AluResult_IN[1:0] != 2'b00);
    assign aligned_acc = access & ~misaligned;
    // Bits above the word index are dropped so addresses wrap modulo DEPTH words.
    assign idx         = AluResult_IN[ADDR_BITS+1:2];

    always_comb begin
        stall_c    = 1'b0;
        complete_c = 1'b0;
        case (state_q)
            StIdle: begin
                stall_c    = aligned_acc & Multi;
                complete_c = ~(aligned_acc & Multi);
            end
            StBusy: begin
                stall_c    = (cnt_q != '0);
                complete_c = (cnt_q == '0);
            end
            default: begin
                stall_c    = 1'b0;
                complete_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wb_q    <= 2'b00;
            rdata_q <= '0;
            alu_q   <= '0;
            wr_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (aligned_acc && Multi) begin
                        state_q <= StBusy;
                        cnt_q   <= CntLoad;
                    end
                end
                StBusy: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (complete_c) begin
                alu_q   <= AluResult_IN;
                wr_q    <= WR_IN;
                fault_q <= misaligned;
                wb_q    <= misaligned ? 2'b00 : WB_IN;
                rdata_q <= (aligned_acc && mem_read) ? mem_q[idx] : '0;
            end else begin
                wb_q    <= 2'b00;
                rdata_q <= '0;
                alu_q   <= '0;
                wr_q    <= '0;
                fault_q <= 1'b0;
            end
        end
    end

    // Write lands on the completing edge only; a reset on that edge aborts it.
    always_ff @(posedge Clk) begin
        if (!Reset && complete_c && aligned_acc && mem_write) begin
            mem_q[idx] <= RD2_IN;
        end
    end

    assign PCSrc         = MEM_IN[2] & Zero_IN;
    assign BranchPC      = BranchPC_IN;
    assign Stall         = stall_c;
    assign WB_OUT        = wb_q;
    assign ReadData_OUT  = rdata_q;
    assign AluResult_OUT = alu_q;
    assign WR_OUT        = wr_q;
    assign Fault_OUT     = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one single-cycle instance and one three-cycle instance
// share the same stimulus.
module tb_mem_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  wb_in;
    logic [2:0]  mem_in;
    logic [31:0] bpc_in;
    logic        zero_in;
    logic [31:0] alu_in;
    logic [31:0] rd2_in;
    logic [4:0]  wr_in;

    logic        pcsrc1, stall1, f1, pcsrc3, stall3, f3;
    logic [31:0] bpc1, rd1, ar1, bpc3, rd3, ar3;
    logic [1:0]  wb1, wb3;
    logic [4:0]  wr1, wr3;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    mem_stage #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(1)) u1 (
        .Clk(Clk), .Reset(Reset), .WB_IN(wb_in), .MEM_IN(mem_in), .BranchPC_IN(bpc_in),
        .Zero_IN(zero_in), .AluResult_IN(alu_in), .RD2_IN(rd2_in), .WR_IN(wr_in),
        .PCSrc(pcsrc1), .BranchPC(bpc1), .Stall(stall1), .WB_OUT(wb1), .ReadData_OUT(rd1),
        .AluResult_OUT(ar1), .WR_OUT(wr1), .Fault_OUT(f1)
    );

    mem_stage #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(3)) u3 (
        .Clk(Clk), .Reset(Reset), .WB_IN(wb_in), .MEM_IN(mem_in), .BranchPC_IN(bpc_in),
        .Zero_IN(zero_in), .AluResult_IN(alu_in), .RD2_IN(rd2_in), .WR_IN(wr_in),
        .PCSrc(pcsrc3), .BranchPC(bpc3), .Stall(stall3), .WB_OUT(wb3), .ReadData_OUT(rd3),
        .AluResult_OUT(ar3), .WR_OUT(wr3), .Fault_OUT(f3)
    );

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] w, input logic [2:0] m, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r);
        wb_in  = w;
        mem_in = m;
        alu_in = a;
        rd2_in = d;
        wr_in  = r;
    endtask

    task automatic idle();
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
    endtask

    // Held for three cycles so both instances complete and end in IDLE.
    task automatic store_hold(input logic [31:0] a, input logic [31:0] d);
        drive(2'b00, 3'b001, a, d, 5'd0);
        repeat (3) cyc();
        idle();
    endtask

    task automatic load_hold(input logic [31:0] a, input logic [4:0] r);
        drive(2'b11, 3'b010, a, 32'h0, r);
        repeat (3) cyc();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (wb1 !== 2'b00) begin errors++; $display("FAIL rst_wb got=%b exp=00", wb1); end
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rst_rd got=%h exp=0", rd1); end
        checks++; if (ar1 !== 32'h0) begin errors++; $display("FAIL rst_ar got=%h exp=0", ar1); end
        checks++; if (wr1 !== 5'd0) begin errors++; $display("FAIL rst_wr got=%0d exp=0", wr1); end
        checks++; if (f1 !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", f1); end
        checks++; if (stall3 !== 1'b0) begin errors++; $display("FAIL rst_stall3 got=%b exp=0", stall3); end
    endtask

    task automatic test_store_load_l1();
        do_reset();
        drive(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0);
        #1;
        checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL l1_sw_stall got=%b exp=0", stall1); end
        cyc();
        checks++; if (wb1 !== 2'b00) begin errors++; $display("FAIL l1_sw_wb got=%b exp=00", wb1); end
        checks++; if (ar1 !== 32'h10) begin errors++; $display("FAIL l1_sw_ar got=%h exp=10", ar1); end
        drive(2'b11, 3'b010, 32'h10, 32'h0, 5'd5);
        #1;
        checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL l1_lw_stall got=%b exp=0", stall1); end
        cyc();
        checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL l1_lw_rd got=%h exp=deadbeef", rd1); end
        checks++; if (wr1 !== 5'd5) begin errors++; $display("FAIL l1_lw_wr got=%0d exp=5", wr1); end
        checks++; if (wb1 !== 2'b11) begin errors++; $display("FAIL l1_lw_wb got=%b exp=11", wb1); end
        drive(2'b10, 3'b000, 32'h77, 32'h0, 5'd3);
        cyc();
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL l1_alu_rd got=%h exp=0", rd1); end
        checks++; if (ar1 !== 32'h77) begin errors++; $display("FAIL l1_alu_ar got=%h exp=77", ar1); end
        checks++; if (wb1 !== 2'b10) begin errors++; $display("FAIL l1_alu_wb got=%b exp=10", wb1); end
        idle();
    endtask

    task automatic test_latency3();
        do_reset();
        store_hold(32'h20, 32'h12345678);
        drive(2'b11, 3'b010, 32'h20, 32'h0, 5'd7);
        #1;
        checks++; if (stall3 !== 1'b1) begin errors++; $display("FAIL l3_stall_t0 got=%b exp=1", stall3); end
        cyc();
        checks++; if (wb3 !== 2'b00) begin errors++; $display("FAIL l3_bubble1_wb got=%b exp=00", wb3); end
        checks++; if (stall3 !== 1'b1) begin errors++; $display("FAIL l3_stall_t1 got=%b exp=1", stall3); end
        cyc();
        checks++; if (wb3 !== 2'b00) begin errors++; $display("FAIL l3_bubble2_wb got=%b exp=00", wb3); end
        checks++; if (stall3 !== 1'b0) begin errors++; $display("FAIL l3_stall_t2 got=%b exp=0", stall3); end
        cyc();
        checks++; if (rd3 !== 32'h12345678) begin errors++; $display("FAIL l3_rd got=%h exp=12345678", rd3); end
        checks++; if (wb3 !== 2'b11) begin errors++; $display("FAIL l3_wb got=%b exp=11", wb3); end
        checks++; if (wr3 !== 5'd7) begin errors++; $display("FAIL l3_wr got=%0d exp=7", wr3); end
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        drive(2'b00, 3'b100, 32'h0, 32'h0, 5'd0);
        bpc_in  = 32'h40;
        zero_in = 1'b1;
        #1;
        checks++; if (pcsrc1 !== 1'b1) begin errors++; $display("FAIL br_taken1 got=%b exp=1", pcsrc1); end
        checks++; if (pcsrc3 !== 1'b1) begin errors++; $display("FAIL br_taken3 got=%b exp=1", pcsrc3); end
        checks++; if (bpc1 !== 32'h40) begin errors++; $display("FAIL br_pc got=%h exp=40", bpc1); end
        zero_in = 1'b0;
        #1;
        checks++; if (pcsrc1 !== 1'b0) begin errors++; $display("FAIL br_nz got=%b exp=0", pcsrc1); end
        mem_in  = 3'b000;
        zero_in = 1'b1;
        #1;
        checks++; if (pcsrc3 !== 1'b0) begin errors++; $display("FAIL br_nobr got=%b exp=0", pcsrc3); end
        zero_in = 1'b0;
        bpc_in  = 32'h0;
        idle();
    endtask

    task automatic test_misaligned();
        do_reset();
        store_hold(32'h20, 32'h11111111);
        drive(2'b11, 3'b001, 32'h22, 32'h99999999, 5'd4);
        #1;
        checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL mis_stall1 got=%b exp=0", stall1); end
        checks++; if (stall3 !== 1'b0) begin errors++; $display("FAIL mis_stall3 got=%b exp=0", stall3); end
        cyc();
        checks++; if (f1 !== 1'b1) begin errors++; $display("FAIL mis_fault1 got=%b exp=1", f1); end
        checks++; if (f3 !== 1'b1) begin errors++; $display("FAIL mis_fault3 got=%b exp=1", f3); end
        checks++; if (wb1 !== 2'b00) begin errors++; $display("FAIL mis_wb1 got=%b exp=00", wb1); end
        checks++; if (wb3 !== 2'b00) begin errors++; $display("FAIL mis_wb3 got=%b exp=00", wb3); end
        idle();
        cyc();
        checks++; if (f1 !== 1'b0) begin errors++; $display("FAIL mis_fault_clr got=%b exp=0", f1); end
        load_hold(32'h20, 5'd2);
        checks++; if (rd1 !== 32'h11111111) begin errors++; $display("FAIL mis_keep1 got=%h exp=11111111", rd1); end
        checks++; if (rd3 !== 32'h11111111) begin errors++; $display("FAIL mis_keep3 got=%h exp=11111111", rd3); end
    endtask

    task automatic test_read_write();
        do_reset();
        store_hold(32'h50, 32'hCAFEF00D);
        drive(2'b11, 3'b011, 32'h50, 32'h0BADF00D, 5'd9);
        cyc();
        checks++; if (rd1 !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_old1 got=%h exp=cafef00d", rd1); end
        repeat (2) cyc();
        checks++; if (rd3 !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_old3 got=%h exp=cafef00d", rd3); end
        idle();
        load_hold(32'h50, 5'd1);
        checks++; if (rd1 !== 32'h0BADF00D) begin errors++; $display("FAIL rw_new1 got=%h exp=0badf00d", rd1); end
        checks++; if (rd3 !== 32'h0BADF00D) begin errors++; $display("FAIL rw_new3 got=%h exp=0badf00d", rd3); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        store_hold(32'h30, 32'h55555555);
        drive(2'b00, 3'b001, 32'h30, 32'hAAAA0000, 5'd6);
        #1;
        checks++; if (stall3 !== 1'b1) begin errors++; $display("FAIL rb_stall_t0 got=%b exp=1", stall3); end
        cyc();
        checks++; if (stall3 !== 1'b1) begin errors++; $display("FAIL rb_stall_t1 got=%b exp=1", stall3); end
        cyc();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        idle();
        #1;
        checks++; if (stall3 !== 1'b0) begin errors++; $display("FAIL rb_stall_after got=%b exp=0", stall3); end
        checks++; if (ar3 !== 32'h0) begin errors++; $display("FAIL rb_ar got=%h exp=0", ar3); end
        checks++; if (wr3 !== 5'd0) begin errors++; $display("FAIL rb_wr got=%0d exp=0", wr3); end
        checks++; if (wb3 !== 2'b00) begin errors++; $display("FAIL rb_wb got=%b exp=00", wb3); end
        load_hold(32'h30, 5'd8);
        checks++; if (rd3 !== 32'h55555555) begin errors++; $display("FAIL rb_mem got=%h exp=55555555", rd3); end
    endtask

    task automatic test_wrap();
        do_reset();
        store_hold(32'h400, 32'h5);
        load_hold(32'h0, 5'd3);
        checks++; if (rd1 !== 32'h5) begin errors++; $display("FAIL wrap1 got=%h exp=5", rd1); end
        checks++; if (rd3 !== 32'h5) begin errors++; $display("FAIL wrap3 got=%h exp=5", rd3); end
    endtask

    initial begin
        Reset   = 1'b1;
        bpc_in  = 32'h0;
        zero_in = 1'b0;
        idle();
        test_reset();
        test_store_load_l1();
        test_latency3();
        test_branch();
        test_misaligned();
        test_read_write();
        test_reset_busy();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
